// File: rtl/debug_pkg.sv
// debug_pkg: shared word width, tag placement and FSM encoding for debug_arbiter.
package debug_pkg;
    localparam int DBG_WORD_W  = 40;
    localparam int DBG_TAG_W   = 3;
    localparam int DBG_TAG_MSB = 39;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, GAP} dbg_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, search starts at last_grant+1 modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic [IW-1:0] ci;
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        ci    = '0;
        for (int k = 1; k <= N; k++) begin
            ci = IW'((int'(last_grant) + k) % N);
            if (!valid && req[ci]) begin
                valid     = 1'b1;
                grant[ci] = 1'b1;
                idx       = ci;
            end
        end
    end
endmodule

// File: rtl/debug_arbiter.sv
// debug_arbiter: round-robin arbiter feeding one 40-bit word at a time to a serial sender.
// Define DEBUG_ARB_TAG_EN to stamp the winner index into out_data[39:37].
module debug_arbiter
    import debug_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DBG_WORD_W-1:0] req_data,
    output logic [N_REQ-1:0]            gnt,
    output logic                        out_valid,
    output logic [DBG_WORD_W-1:0]       out_data,
    input  logic                        sender_busy,
    output logic [15:0]                 sent_count
);
    localparam int IW = $clog2(N_REQ);

    dbg_state_t state, next_state;
    logic [3:0] gap_cnt;
    logic [IW-1:0] last_grant, win_idx;
    logic [N_REQ-1:0] win_onehot;
    logic any_req, take;
    logic [DBG_WORD_W-1:0] win_word, cap_word;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req       (req),
        .last_grant(last_grant),
        .grant     (win_onehot),
        .idx       (win_idx),
        .valid     (any_req)
    );

    assign win_word = req_data[DBG_WORD_W*win_idx +: DBG_WORD_W];
`ifdef DEBUG_ARB_TAG_EN
    assign cap_word = {DBG_TAG_W'(win_idx), win_word[DBG_TAG_MSB-DBG_TAG_W:0]};
`else
    assign cap_word = win_word;
`endif
    // Gated by reset so a requester never sees a grant for a word that is about to be dropped.
    assign take = (state == IDLE) && any_req && !sender_busy && !reset;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = take ? ISSUE : IDLE;
            ISSUE:   next_state = sender_busy ? DRAIN : ISSUE;
            DRAIN:   next_state = sender_busy ? DRAIN : (GAP_CYCLES == 0 ? IDLE : GAP);
            GAP:     next_state = (gap_cnt <= 4'd1) ? IDLE : GAP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gnt       = take ? win_onehot : '0;
        out_valid = (state == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt    <= '0;
            last_grant <= IW'(N_REQ - 1);
            out_data   <= '0;
            sent_count <= '0;
        end else begin
            if (take) begin
                out_data   <= cap_word;
                last_grant <= win_idx;
            end
            if (state == ISSUE && sender_busy) sent_count <= sent_count + 16'd1;
            if (state == DRAIN && !sender_busy) gap_cnt <= 4'(GAP_CYCLES);
            else if (state == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_debug_arbiter.sv
// tb_debug_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_debug_arbiter;
    localparam int N = 4;
    localparam int GAP = 3;
    localparam int W = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] req_data = '0;
    logic sender_busy = 1'b0;
    logic [N-1:0] gnt;
    logic out_valid;
    logic [W-1:0] out_data;
    logic [15:0] sent_count;

    always #5 clk = ~clk;

    debug_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .sender_busy(sender_busy),
        .sent_count (sent_count)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_last = N - 1;
    bit m_out = 1'b0;
    bit m_acc = 1'b0;
    int m_free = 0;
    logic [15:0] m_cnt = '0;
    logic [W-1:0] m_dout = '0;
    logic [N-1:0] eg;
    int egi;
    int dq[$];
    int bcnt = 0;
    logic [N-1:0] s_gnt;
    logic s_valid;
    logic [W-1:0] s_data;
    logic [15:0] s_cnt;

    function automatic logic [W-1:0] tagw(logic [W-1:0] w, int i);
`ifdef DEBUG_ARB_TAG_EN
        return {3'(i), w[36:0]};
`else
        return w;
`endif
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge from the inputs it saw.
    task automatic tick();
        @(negedge clk);
        eg = '0;
        egi = -1;
        if (!reset && !m_out && cyc >= m_free && !sender_busy)
            for (int k = 1; k <= N; k++) begin
                int j = (m_last + k) % N;
                if (egi < 0 && req[j]) egi = j;
            end
        if (egi >= 0) eg[egi] = 1'b1;
        s_gnt = gnt;
        s_valid = out_valid;
        s_data = out_data;
        s_cnt = sent_count;
        for (int i = 0; i < N; i++) if (gnt[i]) dq.push_back(i);
        check("gnt", 64'(gnt), 64'(eg));
        check("out_valid", 64'(out_valid), 64'(m_out && !m_acc));
        check("out_data", 64'(out_data), 64'(m_dout));
        check("sent_count", 64'(sent_count), 64'(m_cnt));
        @(posedge clk);
        if (reset) begin
            m_last = N - 1; m_out = 0; m_acc = 0; m_free = 0; m_cnt = '0; m_dout = '0;
        end else if (egi >= 0) begin
            m_out = 1; m_acc = 0; m_last = egi;
            m_dout = tagw(req_data[W*egi +: W], egi);
        end else if (m_out && !m_acc && sender_busy) begin
            m_acc = 1; m_cnt++;
        end else if (m_out && m_acc && !sender_busy) begin
            m_out = 0; m_free = cyc + 1 + GAP;
        end
        cyc++;
        #1;
    endtask

    task automatic auto_sender();
        if (sender_busy) begin
            bcnt++;
            if (bcnt >= 2) sender_busy = 1'b0;
        end else if (m_out && !m_acc) begin
            sender_busy = 1'b1;
            bcnt = 0;
        end
    endtask

    task automatic run_sender(int n);
        for (int i = 0; i < n; i++) begin
            tick();
            auto_sender();
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        tick(); tick();
        check("rst_valid", 64'(s_valid), 64'd0);
        check("rst_count", 64'(s_cnt), 64'd0);
        reset = 1'b0;

        // single request
        req = 4'b0001;
        req_data[39:0] = 40'hA5_0000_0001;
        tick();
        check("single_gnt", 64'(s_gnt), 64'b0001);
        req = '0;
        tick();
        check("single_valid", 64'(s_valid), 64'd1);
        check("single_data", 64'(s_data), 64'(tagw(40'hA5_0000_0001, 0)));
        sender_busy = 1'b1;
        tick();
        tick();
        check("single_drop", 64'(s_valid), 64'd0);
        check("single_count", 64'(s_cnt), 64'd1);
        sender_busy = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // sender busy in IDLE blocks grants
        sender_busy = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("busy_nogrant", 64'(s_gnt), 64'd0);
        end
        sender_busy = 1'b0;
        tick();
        check("busy_release_gnt", 64'(s_gnt), 64'b0010);
        req = '0;
        sender_busy = 1'b1;
        tick();
        tick();
        // gap: busy falls at T, next grant four cycles later
        sender_busy = 1'b0;
        req = 4'b0001;
        for (n = 0; n < 10; n++) begin
            tick();
            if (s_gnt != 0) break;
        end
        check("gap_latency", 64'(n), 64'd4);
        req = '0;
        run_sender(12);

        // reset during DRAIN, tag / passthrough on requester 2
        req = 4'b0100;
        req_data[2*W +: W] = 40'hFF_FFFF_FFFF;
        tick();
        check("r2_gnt", 64'(s_gnt), 64'b0100);
        req = '0;
        tick();
`ifdef DEBUG_ARB_TAG_EN
        check("tag_data", 64'(s_data), 64'h5F_FFFF_FFFF);
`else
        check("tag_data", 64'(s_data), 64'hFF_FFFF_FFFF);
`endif
        sender_busy = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sender_busy = 1'b0;
        req = 4'b1111;
        tick();
        check("abort_valid", 64'(s_valid), 64'd0);
        check("abort_count", 64'(s_cnt), 64'd0);
        check("abort_gnt", 64'(s_gnt), 64'b0001);
        req = '0;
        run_sender(12);

        // fairness with all requesters held high
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) req_data[W*i +: W] = {8'(8'h11 * (i + 1)), 32'hC0DE_0000 + 32'(i)};
        req = '1;
        dq.delete();
        run_sender(60);
        check("rr_len", 64'(dq.size() >= 5), 64'd1);
        for (int k = 0; k < 5; k++) check("rr_order", 64'(k < dq.size() ? dq[k] : -1), 64'(k % N));
        req = '0;
        run_sender(12);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (eg[i]) begin
                    req[i] = 1'($urandom % 2);
                    req_data[W*i +: W] = W'({$urandom, $urandom});
                end else if (req[i]) begin
                    if ($urandom % 40 == 0) req[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    req[i] = 1'b1;
                    req_data[W*i +: W] = W'({$urandom, $urandom});
                end
            end
            if (sender_busy) sender_busy = ($urandom % 3) != 0;
            else sender_busy = (m_out && !m_acc) ? ($urandom % 4 == 0) : ($urandom % 10 == 0);
            reset = ($urandom % 250 == 0);
        end
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
